// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the requester-side and downstream-side signals of the 4:1 round-robin mux arbiter.
// The slave modport is the arbiter; the master modport is whatever drives the requesters and the sink.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [3:0]         last;
    logic [4*WIDTH-1:0] data_in;
    logic               out_ready;
    logic [3:0]         grant;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;

    modport master (
        output req, last, data_in, out_ready,
        input  grant, sel, out_valid, out_data
    );

    modport slave (
        input  req, last, data_in, out_ready,
        output grant, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that sequences the select of a 4:1 mux under a valid/ready handshake.
// Optional multi-beat grants are enabled with the MUX_ARB_BURST_EN macro.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux4_rr_arbiter_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_grant, w_grant_next;
    logic [1:0] r_sel, w_sel_next;
    logic [1:0] r_ptr, w_ptr_next;
    logic       r_valid, w_valid_next;

    logic [WIDTH-1:0] w_slice [4];
    logic [3:0]       w_arb_req;
    logic [1:0]       w_arb_ptr;
    logic [1:0]       w_win;
    logic             w_any;
    logic             w_abort;
    logic             w_accept;
    logic             w_burst_more;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_slice[gi] = bus.data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_abort  = (r_state == GRANT) && !bus.req[r_sel];
    assign w_accept = (r_state == GRANT) && bus.req[r_sel] && bus.out_ready;

    // While granted, the current owner is excluded and the search starts just past it,
    // which is exactly where the pointer will land if this beat completes the grant.
    assign w_arb_req = (r_state == GRANT) ? (bus.req & ~r_grant) : bus.req;
    assign w_arb_ptr = (r_state == GRANT) ? (r_sel + 2'd1) : r_ptr;
    assign w_any     = |w_arb_req;

    always_comb begin
        logic [1:0] idx;
        w_win = 2'd0;
        idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = w_arb_ptr + 2'(k);
            if (w_arb_req[idx]) begin
                w_win = idx;
            end
        end
    end

`ifdef MUX_ARB_BURST_EN
    localparam int                CW       = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0]     BEAT_MAX = CW'(MAX_BURST - 1);

    logic [CW-1:0] r_beat, w_beat_next;

    assign w_burst_more = !bus.last[r_sel] && (r_beat < BEAT_MAX);

    always_comb begin
        w_beat_next = r_beat;
        if (w_abort) begin
            w_beat_next = '0;
        end else if (w_accept) begin
            w_beat_next = w_burst_more ? (r_beat + CW'(1)) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else begin
            r_beat <= w_beat_next;
        end
    end
`else
    assign w_burst_more = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_sel_next   = r_sel;
        w_ptr_next   = r_ptr;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = GRANT;
                    w_grant_next = 4'b0001 << w_win;
                    w_sel_next   = w_win;
                    w_valid_next = 1'b1;
                end
            end
            GRANT: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                    w_grant_next = 4'b0000;
                    w_valid_next = 1'b0;
                end else if (w_accept && !w_burst_more) begin
                    w_ptr_next = r_sel + 2'd1;
                    if (w_any) begin
                        w_grant_next = 4'b0001 << w_win;
                        w_sel_next   = w_win;
                    end else begin
                        w_state_next = IDLE;
                        w_grant_next = 4'b0000;
                        w_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = 4'b0000;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_sel   <= w_sel_next;
            r_ptr   <= w_ptr_next;
            r_valid <= w_valid_next;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_valid ? w_slice[r_sel] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_mux4_rr_arbiter;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rst_n;

    logic [3:0]   t_req;
    logic [3:0]   t_last;
    logic [W-1:0] t_data [4];
    logic         t_ready;

    int n_vec;
    int n_err;

    // behavioural model state
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_cnt;
    int m_acc;

    mux4_rr_arbiter_if #(.WIDTH(W)) bus ();

    mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.req       = t_req;
    assign bus.last      = t_last;
    assign bus.out_ready = t_ready;
    assign bus.data_in   = {t_data[3], t_data[2], t_data[1], t_data[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {bus.out_valid, bus.grant, bus.sel, bus.out_data};
    endfunction

    function automatic logic [12:0] obs_ns();
        return {bus.out_valid, bus.grant, bus.out_data};
    endfunction

    function automatic int pick(logic [3:0] r, int p, int excl);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_acc = -1;
    endtask

    task automatic model_step();
        int  w;
        bit  keep;
        m_acc = -1;
        keep  = 0;
        if (!m_busy) begin
            w = pick(t_req, m_ptr, -1);
            if (w >= 0) begin m_busy = 1; m_g = w; end
        end else if (!t_req[m_g]) begin
            m_busy = 0; m_cnt = 0;
        end else if (t_ready) begin
            m_acc = m_g;
`ifdef MUX_ARB_BURST_EN
            if (!t_last[m_g] && m_cnt < MAX_BURST - 1) begin
                m_cnt++; keep = 1;
            end else begin
                m_cnt = 0;
            end
`endif
            if (!keep) begin
                m_ptr = (m_g + 1) % 4;
                w = pick(t_req, m_ptr, m_g);
                if (w < 0) m_busy = 0;
                else       m_g = w;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; t_req = 4'b0; t_last = 4'hF; t_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; t_req = 4'b1111; t_last = 4'hF; t_ready = 1'b1;
        for (int i = 0; i < 4; i++) t_data[i] = 8'h5A;
        repeat (2) @(negedge clk);
        n_vec++;
        if (obs() !== 15'h0) begin
            n_err++; $display("FAIL reset_state: got %h want %h", obs(), 15'h0);
        end
        t_req = 4'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single();
        t_req = 4'b0100; t_data[2] = 8'hA5; t_ready = 1'b1;
        tick();
        n_vec++;
        if (obs() !== {1'b1, 4'b0100, 2'd2, 8'hA5}) begin
            n_err++; $display("FAIL single_grant: got %h want %h", obs(), {1'b1, 4'b0100, 2'd2, 8'hA5});
        end
        tick();
        t_req = 4'b0;
        n_vec++;
        if (obs_ns() !== 13'h0) begin
            n_err++; $display("FAIL single_release: got %h want %h", obs_ns(), 13'h0);
        end
    endtask

    task automatic test_contention();
        logic [14:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) t_data[i] = W'($urandom);
        t_req = 4'b1111; t_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 4'b0001 << i, 2'(i), t_data[i]};
            n_vec++;
            if (obs() !== exp) begin
                n_err++; $display("FAIL contention_grant%0d: got %h want %h", i, obs(), exp);
            end
            tick();
            t_req[i] = 1'b0;
        end
        n_vec++;
        if (obs_ns() !== 13'h0) begin
            n_err++; $display("FAIL contention_idle: got %h want %h", obs_ns(), 13'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] exp;
        t_data[1] = W'($urandom);
        t_req = 4'b0010; t_ready = 1'b0;
        tick();
        exp = {1'b1, 4'b0010, 2'd1, t_data[1]};
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (obs() !== exp) begin
                n_err++; $display("FAIL backpressure_hold%0d: got %h want %h", c, obs(), exp);
            end
            if (c < 2) tick();
        end
        t_ready = 1'b1;
        tick();
        t_req = 4'b0;
        n_vec++;
        if (obs_ns() !== 13'h0) begin
            n_err++; $display("FAIL backpressure_one_xfer: got %h want %h", obs_ns(), 13'h0);
        end
        tick();
        n_vec++;
        if (obs_ns() !== 13'h0) begin
            n_err++; $display("FAIL backpressure_stay_idle: got %h want %h", obs_ns(), 13'h0);
        end
    endtask

    task automatic test_wrap();
        logic [14:0] exp;
        t_data[0] = 8'h11; t_data[3] = 8'h33; t_ready = 1'b1;
        t_req = 4'b1000;
        tick();
        tick();
        t_req = 4'b1001;
        tick();
        exp = {1'b1, 4'b0001, 2'd0, 8'h11};
        n_vec++;
        if (obs() !== exp) begin
            n_err++; $display("FAIL wrap_to_zero: got %h want %h", obs(), exp);
        end
        tick();
        t_req[0] = 1'b0;
        exp = {1'b1, 4'b1000, 2'd3, 8'h33};
        n_vec++;
        if (obs() !== exp) begin
            n_err++; $display("FAIL wrap_back_to_back: got %h want %h", obs(), exp);
        end
        tick();
        t_req = 4'b0;
    endtask

    task automatic test_async_reset();
        t_data[2] = 8'hC3; t_req = 4'b0100; t_ready = 1'b0;
        tick();
        n_vec++;
        if (obs() !== {1'b1, 4'b0100, 2'd2, 8'hC3}) begin
            n_err++; $display("FAIL async_pre_grant: got %h want %h", obs(), {1'b1, 4'b0100, 2'd2, 8'hC3});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs() !== 15'h0) begin
            n_err++; $display("FAIL async_reset_clear: got %h want %h", obs(), 15'h0);
        end
        @(negedge clk);
        t_req = 4'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

`ifdef MUX_ARB_BURST_EN
    task automatic test_burst();
        logic [14:0] exp;
        do_reset();
        t_req = 4'b1010; t_last = 4'b1000; t_ready = 1'b1;
        t_data[1] = W'($urandom); t_data[3] = W'($urandom);
        tick();
        for (int b = 0; b < 4; b++) begin
            exp = {1'b1, 4'b0010, 2'd1, t_data[1]};
            n_vec++;
            if (obs() !== exp) begin
                n_err++; $display("FAIL burst_beat%0d: got %h want %h", b, obs(), exp);
            end
            tick();
            t_data[1] = W'($urandom);
        end
        t_req[1] = 1'b0;
        exp = {1'b1, 4'b1000, 2'd3, t_data[3]};
        n_vec++;
        if (obs() !== exp) begin
            n_err++; $display("FAIL burst_moves_on: got %h want %h", obs(), exp);
        end
        tick();
        t_req = 4'b0;

        do_reset();
        t_req = 4'b0010; t_last = 4'b0000; t_ready = 1'b1;
        t_data[1] = W'($urandom);
        tick();
        tick();
        t_last[1] = 1'b1; t_data[1] = W'($urandom);
        exp = {1'b1, 4'b0010, 2'd1, t_data[1]};
        n_vec++;
        if (obs() !== exp) begin
            n_err++; $display("FAIL burst_last_beat2: got %h want %h", obs(), exp);
        end
        tick();
        t_req = 4'b0;
        n_vec++;
        if (obs_ns() !== 13'h0) begin
            n_err++; $display("FAIL burst_last_end: got %h want %h", obs_ns(), 13'h0);
        end
    endtask
`endif

    task automatic test_random();
        logic [12:0] exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_acc == i) begin
                    if ($urandom_range(1, 0) == 1) t_req[i] = 1'b0;
                    else begin
                        t_data[i] = W'($urandom);
                        t_last[i] = ($urandom_range(3, 0) == 0);
                    end
                end else if (!t_req[i]) begin
                    if ($urandom_range(99, 0) < 35) begin
                        t_req[i]  = 1'b1;
                        t_data[i] = W'($urandom);
                        t_last[i] = ($urandom_range(3, 0) == 0);
                    end
                end else if (m_busy && m_g == i && $urandom_range(99, 0) < 2) begin
                    t_req[i] = 1'b0;
                end
            end
            t_ready = ($urandom_range(99, 0) < 70);
            tick();
            exp = m_busy ? {1'b1, 4'b0001 << m_g, t_data[m_g]} : 13'h0;
            n_vec++;
            if (obs_ns() !== exp) begin
                n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs_ns(), exp);
            end
            if (m_busy) begin
                n_vec++;
                if (bus.sel !== 2'(m_g)) begin
                    n_err++; $display("FAIL random_sel_c%0d: got %0d want %0d", c, bus.sel, m_g);
                end
            end
        end
        t_req = 4'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_async_reset();
`ifdef MUX_ARB_BURST_EN
        test_burst();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux output channel among four requesters.
- Each requester presents a request plus a data word. The arbiter picks one, drives the mux select and a one-hot grant, and forwards the selected word downstream under a valid/ready handshake.
- Sits in front of the 4:1 mux datapath and sequences its select line.

Parameters:
- WIDTH, 8, data word width per requester.
- MAX_BURST, 4, maximum beats per grant; used only when MUX_ARB_BURST_EN is defined; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; must be held until the requester's beat is accepted.
- last  input  4  final-beat flag per requester; ignored unless MUX_ARB_BURST_EN is defined.
- data_in  input  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]; held stable while req[i] is high.
- out_ready  input  1  downstream ready.
- grant  output  4  one-hot grant, registered; 0 when idle.
- sel  output  2  registered mux select, equal to the index of the granted requester.
- out_valid  output  1  registered; high while a grant is active.
- out_data  output  WIDTH  data_in slice selected by sel when out_valid=1; 0 when out_valid=0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, sel=0, out_valid=0, out_data=0, rotation pointer ptr=0, beat counter=0. Outputs clear immediately without waiting for a clock edge.
- Rotation: the winner is the first requester with req high, searching ptr, ptr+1, ... modulo 4.
- States: IDLE, GRANT.
- IDLE:
  - If any req is high, register the winner: grant[w]=1, sel=w, out_valid=1, go to GRANT.
  - Latency is 1 cycle from req high to out_valid high.
- GRANT, out_ready=1 and req[sel]=1 (accept):
  - One beat transfers.
  - ptr <= sel+1 (3 wraps to 0).
  - Re-arbitrate in the same cycle over req with bit sel masked. If any other requester wins, grant it on the next edge back-to-back, with no idle cycle. Otherwise go to IDLE with grant=0 and out_valid=0.
- GRANT, out_ready=0: hold grant, sel and out_valid; out_data stays stable.
- GRANT, req[sel]=0 before accept (protocol violation): abort and go to IDLE on the next edge, with no transfer and ptr unchanged.
- A single requester cannot be granted back-to-back. It sees at least one IDLE cycle between grants (without the burst feature).
- Simultaneous requests are resolved only by rotation; there is no fixed priority.
- Arbitration and next-grant logic is combinational; grant, sel, out_valid, ptr and state are registered.

Optional Feature:
- Macro MUX_ARB_BURST_EN.
- Defined:
  - On accept, if last[sel]=0 and beat counter < MAX_BURST-1, keep the same grant, increment the counter and leave ptr unchanged. The requester presents its next word the cycle after accept.
  - On accept with last[sel]=1, or with counter = MAX_BURST-1, end the grant: clear the counter and apply the normal rotation/re-arbitration rules.
  - The counter is $clog2(MAX_BURST)+1 bits and is cleared by reset and by abort.
- Not defined: every grant is exactly one beat, last is ignored, and no counter logic exists.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> grant=0000, sel=0, out_valid=0, out_data=0. Assert rst_n=0 mid-GRANT -> all outputs clear before the next clk edge.
- Single request: req=0100, data_in[2]=0xA5, out_ready=1 -> next cycle grant=0100, sel=2, out_valid=1, out_data=0xA5. Requester drops req after accept -> following cycle out_valid=0, grant=0000.
- Full contention: req=1111 from reset, out_ready=1, each requester drops req after its accept -> grants 0001, 0010, 0100, 1000 on four consecutive cycles, then IDLE.
- Backpressure: req=0010, out_ready=0 for 3 cycles -> grant=0010 and out_data constant throughout. Raise out_ready -> exactly one transfer, then IDLE.
- Wrap-around: after a grant to requester 3, present req=1001 -> requester 0 is granted (sel=0).
- Burst (MUX_ARB_BURST_EN, MAX_BURST=4):
  - req[1] with last=0 on every beat -> 4 consecutive beats under grant=0010, then the grant moves on.
  - Same case with last=1 on beat 2 -> the grant ends after 2 beats.
